ioctl_region_loader: RTL and testbench

- Parametrised download router between `data_io` (ioctl byte stream) and the per-ROM/PROM dual-port RAMs of an arcade core.
- Replaces hand-written per-RAM `ioctl_addr` compare logic with a region table supplied as parameters.
- Supports split-lane regions: the lower half of a region feeds byte lane 0 and the upper half feeds lane 1 (16-bit ROM from two 8-bit RAMs).
- Generates the core reset (held during download plus a stretch after it), a done pulse, a byte count, a checksum and an unmapped-write count.

---
 rtl/ioctl_region_loader.sv | 213 +++++++++++++++++++++
 tb/tb_ioctl_region_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_region_loader.sv
// ioctl_region_loader
// Routes the data_io download byte stream into per-region ROM/PROM RAMs
// using a parameterised region table. Split regions feed their lower half
// to byte lane 0 and their upper half to lane 1. Also generates the core
// reset (held through the download plus a stretch), a completion pulse,
// and byte/checksum/unmapped statistics for the current or last download.
module ioctl_region_loader #(
    parameter int                      NUM_RGN       = 8,
    parameter logic [NUM_RGN*25-1:0]   RGN_BASE      = {NUM_RGN{25'd0}},
    parameter logic [NUM_RGN*5-1:0]    RGN_SIZE_LOG2 = {NUM_RGN{5'd13}},
    parameter logic [NUM_RGN-1:0]      RGN_SPLIT     = {NUM_RGN{1'b0}},
    parameter logic [7:0]              ROM_INDEX     = 8'd0,
    parameter int                      RST_HOLD      = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_downl,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic [NUM_RGN-1:0] rgn_we,
    output logic               rgn_lane,
    output logic [23:0]        rgn_addr,
    output logic [7:0]         rgn_data,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic [24:0]        byte_cnt,
    output logic [15:0]        checksum,
    output logic [15:0]        unmapped_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

    // Saturating +1 for the unmapped-byte counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only downloads of our index count; everything else is invisible.
    logic act;
    logic accept;
    assign act    = ioctl_downl && (ioctl_index == ROM_INDEX);
    assign accept = ioctl_wr && act;

    // Per-region decode: match flag, lane and in-region address.
    logic [NUM_RGN-1:0] match;
    logic [NUM_RGN-1:0] lane_a;
    logic [23:0]        addr_a [NUM_RGN];

    for (genvar g = 0; g < NUM_RGN; g++) begin : g_rgn
        localparam logic [24:0] BASE = RGN_BASE[g*25 +: 25];
        localparam int          SZ   = int'(RGN_SIZE_LOG2[g*5 +: 5]);

        logic [24:0] off;
        // Subtraction only matters when addr >= BASE, so it never wraps
        // in the cases that can match.
        assign off      = ioctl_addr - BASE;
        assign match[g] = (ioctl_addr >= BASE) && ((off >> SZ) == 25'd0);

        if (RGN_SPLIT[g]) begin : g_split
            localparam logic [23:0] LANE_MASK = 24'((25'd1 << (SZ - 1)) - 25'd1);
            assign lane_a[g] = off[SZ-1];
            assign addr_a[g] = off[23:0] & LANE_MASK;
        end else begin : g_flat
            assign lane_a[g] = 1'b0;
            assign addr_a[g] = off[23:0];
        end
    end

    // Priority select: lowest-indexed matching region wins.
    logic               hit;
    logic [NUM_RGN-1:0] sel_we;
    logic               sel_lane;
    logic [23:0]        sel_addr;

    always_comb begin
        hit      = 1'b0;
        sel_we   = '0;
        sel_lane = 1'b0;
        sel_addr = '0;
        for (int i = NUM_RGN - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit       = 1'b1;
                sel_we    = '0;
                sel_we[i] = 1'b1;
                sel_lane  = lane_a[i];
                sel_addr  = addr_a[i];
            end
        end
    end

    // Control state and registers.
    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        done_d;
    logic        busy_q, core_reset_q, done_q;

    // Next-state decode; core_reset/busy are registered from state_d so
    // they rise in the same cycle the FSM leaves IDLE.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!act) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            S_HOLD: begin
                if (act) begin
                    state_d = S_LOAD;
                end else if (hold_q <= 8'd1) begin
                    state_d = S_IDLE;
                    hold_d  = 8'd0;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 8'd0;
            end
        endcase
    end

    // Statistics counters, cleared whenever a new download enters LOAD.
    logic        clr;
    logic [24:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] checksum_q, checksum_d;
    logic [15:0] unmapped_q, unmapped_d;

    // Counter next values: optional clear, then the accepted byte on top.
    always_comb begin
        clr        = (state_q != S_LOAD) && (state_d == S_LOAD);
        byte_cnt_d = clr ? 25'd0 : byte_cnt_q;
        checksum_d = clr ? 16'd0 : checksum_q;
        unmapped_d = clr ? 16'd0 : unmapped_q;
        if (accept) begin
            byte_cnt_d = byte_cnt_d + 25'd1;
            checksum_d = checksum_d + {8'd0, ioctl_dout};
            if (!hit) begin
                unmapped_d = sat_inc16(unmapped_d);
            end
        end
    end

    // Write-path output registers.
    logic [NUM_RGN-1:0] rgn_we_q;
    logic               rgn_lane_q;
    logic [23:0]        rgn_addr_q;
    logic [7:0]         rgn_data_q;

    // FSM, registered control outputs, write path and counters.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= 8'd0;
            busy_q       <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            rgn_we_q     <= '0;
            rgn_lane_q   <= 1'b0;
            rgn_addr_q   <= 24'd0;
            rgn_data_q   <= 8'd0;
            byte_cnt_q   <= 25'd0;
            checksum_q   <= 16'd0;
            unmapped_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            busy_q       <= (state_d != S_IDLE);
            core_reset_q <= (state_d != S_IDLE);
            done_q       <= done_d;
            rgn_we_q     <= (accept && hit) ? sel_we : '0;
            if (accept) begin
                rgn_lane_q <= sel_lane;
                rgn_addr_q <= sel_addr;
                rgn_data_q <= ioctl_dout;
            end
            byte_cnt_q   <= byte_cnt_d;
            checksum_q   <= checksum_d;
            unmapped_q   <= unmapped_d;
        end
    end

    assign rgn_we       = rgn_we_q;
    assign rgn_lane     = rgn_lane_q;
    assign rgn_addr     = rgn_addr_q;
    assign rgn_data     = rgn_data_q;
    assign core_reset   = core_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign byte_cnt     = byte_cnt_q;
    assign checksum     = checksum_q;
    assign unmapped_cnt = unmapped_q;

endmodule

// File: tb/tb_ioctl_region_loader.sv
// Testbench for ioctl_region_loader using the Ladybug region map.
module tb_ioctl_region_loader;

    localparam int NUM_RGN = 8;
    localparam logic [NUM_RGN*25-1:0] BASES = {
        25'h0A100, 25'h0A020, 25'h0A000, 25'h08000,
        25'h06000, 25'h04000, 25'h02000, 25'h00000};
    localparam logic [NUM_RGN*5-1:0] SIZES = {
        5'd8, 5'd5, 5'd5, 5'd13, 5'd13, 5'd13, 5'd13, 5'd13};
    localparam logic [NUM_RGN-1:0] SPLITS = 8'b0001_1000;

    logic               clk_sys = 1'b0;
    logic               reset;
    logic               ioctl_downl;
    logic [7:0]         ioctl_index;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic [NUM_RGN-1:0] rgn_we;
    logic               rgn_lane;
    logic [23:0]        rgn_addr;
    logic [7:0]         rgn_data;
    logic               core_reset;
    logic               busy;
    logic               done;
    logic [24:0]        byte_cnt;
    logic [15:0]        checksum;
    logic [15:0]        unmapped_cnt;

    ioctl_region_loader #(
        .NUM_RGN      (NUM_RGN),
        .RGN_BASE     (BASES),
        .RGN_SIZE_LOG2(SIZES),
        .RGN_SPLIT    (SPLITS),
        .ROM_INDEX    (8'd0),
        .RST_HOLD     (16)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .rgn_we      (rgn_we),
        .rgn_lane    (rgn_lane),
        .rgn_addr    (rgn_addr),
        .rgn_data    (rgn_data),
        .core_reset  (core_reset),
        .busy        (busy),
        .done        (done),
        .byte_cnt    (byte_cnt),
        .checksum    (checksum),
        .unmapped_cnt(unmapped_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Count done pulses between edges.
    always @(negedge clk_sys) begin
        if (done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [7:0]  we;
        logic        lane;
        logic [23:0] radr;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done(output int hc, output bit seen, output bit busy_at, output bit cr_at);
        hc      = 0;
        seen    = 1'b0;
        busy_at = 1'b1;
        cr_at   = 1'b1;
        for (int k = 0; k < 64 && !seen; k++) begin
            tick();
            if (done === 1'b1) begin
                seen    = 1'b1;
                busy_at = busy;
                cr_at   = core_reset;
            end else if (core_reset === 1'b1) begin
                hc++;
            end
        end
    endtask

    initial begin
        int          hc;
        bit          seen, b_at, c_at;
        int          exp_unm;
        logic [15:0] exp_sum;
        int          d0;
        logic [7:0]  we_or;
        logic        cr_or, busy_or;

        vec[0]  = '{25'h0002005, 8'h5A, 8'h02, 1'b0, 24'h000005};
        vec[1]  = '{25'h0009003, 8'h33, 8'h10, 1'b1, 24'h000003};
        vec[2]  = '{25'h0006FFF, 8'hC4, 8'h08, 1'b0, 24'h000FFF};
        vec[3]  = '{25'h000A040, 8'h11, 8'h00, 1'b0, 24'h000000};
        vec[4]  = '{25'h000A0FF, 8'h22, 8'h00, 1'b0, 24'h000000};
        vec[5]  = '{25'h000A01F, 8'h7E, 8'h20, 1'b0, 24'h00001F};
        vec[6]  = '{25'h0000000, 8'h01, 8'h01, 1'b0, 24'h000000};
        vec[7]  = '{25'h000A1FF, 8'h99, 8'h80, 1'b0, 24'h0000FF};
        vec[8]  = '{25'h000A200, 8'hAB, 8'h00, 1'b0, 24'h000000};
        vec[9]  = '{25'h0007000, 8'h3C, 8'h08, 1'b1, 24'h000000};
        vec[10] = '{25'h0005FFF, 8'hE7, 8'h04, 1'b0, 24'h001FFF};
        vec[11] = '{25'h1FFFFFF, 8'h42, 8'h00, 1'b0, 24'h000000};
        vec[12] = '{25'h000A020, 8'h5C, 8'h40, 1'b0, 24'h000000};
        vec[13] = '{25'h0008FFF, 8'h10, 8'h10, 1'b0, 24'h000FFF};

        reset       = 1'b1;
        ioctl_downl = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;

        // Reset state
        tick();
        tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", rgn_we, 0);
        check("rst_addr", rgn_addr, 0);
        check("rst_data", rgn_data, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_checksum", checksum, 0);
        check("rst_unmapped", unmapped_cnt, 0);
        reset = 1'b0;
        tick();
        check("idle_core_reset", core_reset, 0);
        check("idle_busy", busy, 0);

        // Table-driven region mapping within one download
        ioctl_downl = 1'b1;
        tick();
        check("start_busy", busy, 1);
        check("start_core_reset", core_reset, 1);
        exp_unm = 0;
        exp_sum = 16'd0;
        for (int i = 0; i < NV; i++) begin
            write_byte(vec[i].addr, vec[i].data);
            exp_sum = exp_sum + {8'd0, vec[i].data};
            if (vec[i].we == 8'd0) exp_unm++;
            check($sformatf("v%0d_we", i), rgn_we, vec[i].we);
            if (vec[i].we != 8'd0) begin
                check($sformatf("v%0d_lane", i), rgn_lane, vec[i].lane);
                check($sformatf("v%0d_addr", i), rgn_addr, vec[i].radr);
                check($sformatf("v%0d_data", i), rgn_data, vec[i].data);
            end
            check($sformatf("v%0d_busy", i), busy, 1);
            check($sformatf("v%0d_core_reset", i), core_reset, 1);
            check($sformatf("v%0d_byte_cnt", i), byte_cnt, i + 1);
            check($sformatf("v%0d_checksum", i), checksum, exp_sum);
            check($sformatf("v%0d_unmapped", i), unmapped_cnt, exp_unm);
            tick();
            check($sformatf("v%0d_we_pulse", i), rgn_we, 0);
        end

        // End of download: reset stretch and done pulse
        ioctl_downl = 1'b0;
        d0 = done_cnt;
        wait_done(hc, seen, b_at, c_at);
        check("t_done_seen", seen, 1);
        check("t_hold_cycles", hc, 16);
        check("t_busy_at_done", b_at, 0);
        check("t_core_reset_at_done", c_at, 0);
        tick();
        check("t_done_one_cycle", done, 0);
        check("t_done_count", done_cnt - d0, 1);
        check("t_byte_cnt_hold", byte_cnt, NV);
        check("t_checksum_hold", checksum, exp_sum);

        // Three bytes, checksum and hold
        ioctl_downl = 1'b1;
        tick();
        check("s4_cleared_cnt", byte_cnt, 0);
        check("s4_cleared_sum", checksum, 0);
        check("s4_cleared_unm", unmapped_cnt, 0);
        write_byte(25'h10, 8'h01);
        write_byte(25'h11, 8'hFF);
        write_byte(25'h12, 8'h80);
        ioctl_downl = 1'b0;
        d0 = done_cnt;
        wait_done(hc, seen, b_at, c_at);
        check("s4_byte_cnt", byte_cnt, 3);
        check("s4_checksum", checksum, 16'h0180);
        check("s4_done_seen", seen, 1);
        check("s4_hold_cycles", hc, 16);
        check("s4_busy_at_done", b_at, 0);
        tick();
        check("s4_done_count", done_cnt - d0, 1);

        // Reset in the middle of a 100-byte download
        ioctl_downl = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(i);
            tick();
        end
        ioctl_wr = 1'b0;
        check("s5_byte_cnt_100", byte_cnt, 100);
        check("s5_checksum_100", checksum, 16'h1356);
        d0 = done_cnt;
        reset       = 1'b1;
        ioctl_downl = 1'b0;
        tick();
        reset = 1'b0;
        check("s5_rst_busy", busy, 0);
        check("s5_rst_core_reset", core_reset, 1);
        check("s5_rst_byte_cnt", byte_cnt, 0);
        check("s5_rst_checksum", checksum, 0);
        check("s5_rst_we", rgn_we, 0);
        tick();
        check("s5_post_core_reset", core_reset, 0);
        for (int i = 0; i < 20; i++) tick();
        check("s5_no_done", done_cnt - d0, 0);
        ioctl_downl = 1'b1;
        tick();
        check("s5_restart_busy", busy, 1);
        write_byte(25'h4001, 8'h20);
        check("s5_restart_we", rgn_we, 8'h04);
        check("s5_restart_addr", rgn_addr, 24'h001);
        write_byte(25'h4002, 8'h21);
        ioctl_downl = 1'b0;
        wait_done(hc, seen, b_at, c_at);
        check("s5_restart_done", seen, 1);
        check("s5_restart_byte_cnt", byte_cnt, 2);
        check("s5_restart_checksum", checksum, 16'h0041);
        tick();

        // Foreign-index download is ignored
        ioctl_index = 8'h01;
        ioctl_downl = 1'b1;
        we_or   = 8'd0;
        cr_or   = 1'b0;
        busy_or = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            write_byte(25'h2000 + 25'(i), 8'(8'hA0 + i));
            we_or   = we_or | rgn_we;
            cr_or   = cr_or | core_reset;
            busy_or = busy_or | busy;
        end
        tick();
        check("s6_idx1_we", we_or, 0);
        check("s6_idx1_core_reset", cr_or, 0);
        check("s6_idx1_busy", busy_or, 0);
        check("s6_idx1_byte_cnt", byte_cnt, 2);
        check("s6_idx1_checksum", checksum, 16'h0041);
        ioctl_downl = 1'b0;
        ioctl_index = 8'h00;
        tick();

        // Re-entering LOAD from HOLD
        ioctl_downl = 1'b1;
        tick();
        write_byte(25'h2000, 8'h77);
        ioctl_downl = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("s6_hold_busy", busy, 1);
        check("s6_hold_byte_cnt", byte_cnt, 1);
        d0 = done_cnt;
        ioctl_downl = 1'b1;
        tick();
        check("s6_reload_busy", busy, 1);
        check("s6_reload_byte_cnt", byte_cnt, 0);
        check("s6_reload_checksum", checksum, 0);
        for (int i = 0; i < 20; i++) tick();
        check("s6_reload_no_done", done_cnt - d0, 0);
        write_byte(25'h0003, 8'h05);
        check("s6_reload_we", rgn_we, 8'h01);
        ioctl_downl = 1'b0;
        wait_done(hc, seen, b_at, c_at);
        check("s6_final_done", seen, 1);
        check("s6_final_hold", hc, 16);
        tick();
        check("s6_final_done_count", done_cnt - d0, 1);
        check("s6_final_byte_cnt", byte_cnt, 1);
        check("s6_final_checksum", checksum, 16'h0005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
